pipelined_adder: RTL

Parametrised, pipelined ripple-carry adder with valid/ready flow control. The carry chain is split into CHUNK-bit slices, one register stage per slice, so wide additions meet timing at one result per cycle. It is the clocked, width-generic successor to the single-bit full adder and serves as the arithmetic building block for wide datapaths, such as accumulators and address generators, that need a streaming handshake.

---
 rtl/pipelined_adder_if.sv | 38 +++
 rtl/pipelined_adder.sv | 115 +++++++++++
 2 files changed

// File: rtl/pipelined_adder_if.sv
`default_nettype none
// pipelined_adder_if: valid/ready operand and result bus for pipelined_adder.
// The ovf signal exists only when PIPE_ADDER_OVF_EN is defined.
interface pipelined_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             cout;
`ifdef PIPE_ADDER_OVF_EN
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, s, cout, ovf
   );
   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, s, cout, ovf
   );
`else
   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, s, cout
   );
   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, s, cout
   );
`endif
endinterface
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
//==============================================================================
// pipelined_adder: CHUNK-bit-per-stage ripple-carry adder, valid/ready stream.
// Optional signed overflow flag with PIPE_ADDER_OVF_EN.  Rev 1.0
//==============================================================================
module pipelined_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   pipelined_adder_if.slave bus
);
   localparam int STAGES = WIDTH / CHUNK;

   genvar k;
   generate
      for (k = 0; k < STAGES; k++) begin : g_stage
         localparam int LOW = k * CHUNK;
         localparam int OPW = WIDTH - LOW;
         localparam int SW  = LOW + CHUNK;

         logic           r_v;
         logic           r_c;
         logic [SW-1:0]  r_sum;
         logic           w_acc;
         logic           w_up_v;
         logic           w_cin;
         logic [OPW-1:0] w_a;
         logic [OPW-1:0] w_b;
         logic [SW-1:0]  w_sum;
         logic [CHUNK:0] w_add;
         logic           w_load;

         assign w_add  = {1'b0, w_a[CHUNK-1:0]} + {1'b0, w_b[CHUNK-1:0]}
                       + {{CHUNK{1'b0}}, w_cin};
         assign w_load = w_acc && w_up_v;

         if (k == 0) begin : g_first
            assign w_up_v = bus.in_valid;
            assign w_cin  = bus.cin;
            assign w_a    = bus.a;
            assign w_b    = bus.b;
            assign w_sum  = w_add[CHUNK-1:0];
         end else begin : g_next
            assign w_up_v = g_stage[k-1].r_v;
            assign w_cin  = g_stage[k-1].r_c;
            assign w_a    = g_stage[k-1].g_mid.r_a;
            assign w_b    = g_stage[k-1].g_mid.r_b;
            assign w_sum  = {w_add[CHUNK-1:0], g_stage[k-1].r_sum};
         end

         // A stage drops its valid bit when it accepts with nothing upstream,
         // which is what lets bubbles collapse.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_v   <= 1'b0;
               r_c   <= 1'b0;
               r_sum <= '0;
            end else begin
               if (w_acc) begin
                  r_v <= w_up_v;
               end
               if (w_load) begin
                  r_c   <= w_add[CHUNK];
                  r_sum <= w_sum;
               end
            end
         end

         if (k == STAGES-1) begin : g_last
            assign w_acc = !r_v || bus.out_ready;
`ifdef PIPE_ADDER_OVF_EN
            logic r_ovf;
            logic w_ovf;

            assign w_ovf = (w_a[OPW-1] == w_b[OPW-1]) && (w_add[CHUNK-1] != w_a[OPW-1]);

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  r_ovf <= 1'b0;
               end else if (w_load) begin
                  r_ovf <= w_ovf;
               end
            end

            assign bus.ovf = r_ovf;
`endif
         end else begin : g_mid
            logic [OPW-CHUNK-1:0] r_a;
            logic [OPW-CHUNK-1:0] r_b;

            assign w_acc = !r_v || g_stage[k+1].w_acc;

            // Skew registers: operand bits not yet added travel with the sum.
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  r_a <= '0;
                  r_b <= '0;
               end else if (w_load) begin
                  r_a <= w_a[OPW-1:CHUNK];
                  r_b <= w_b[OPW-1:CHUNK];
               end
            end
         end
      end
   endgenerate

   assign bus.in_ready  = g_stage[0].w_acc;
   assign bus.out_valid = g_stage[STAGES-1].r_v;
   assign bus.s         = g_stage[STAGES-1].r_sum;
   assign bus.cout      = g_stage[STAGES-1].r_c;

endmodule
`default_nettype wire
